// File: rtl/rs_param_pkg.sv
// Shared constants for the reservation-station family.
// Holds the "no dependency" tag value, the NOP opcode used as the idle
// output value, default sizing, and a clog2 helper usable in port widths.
package rs_param_pkg;

  localparam int TAG_ZERO         = 0;   // tag value meaning "operand valid"
  localparam int OP_NOP           = 0;   // opcode driven while idle/reset
  localparam int RS_DEPTH_DEFAULT = 16;
  localparam int RS_N_CDB_DEFAULT = 3;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/rs_age_picker.sv
// Oldest-first picker driven by an age matrix.
// age[i][j] = 1 means entry j is older than entry i. An entry is granted
// when it is ready and no older entry is also ready; the matrix is a strict
// total order over live entries, so the grant is one-hot or zero.
// Ports:
//   ready     in   per-entry ready vector
//   age       in   DEPTH x DEPTH age matrix (row i = entries older than i)
//   grant     out  one-hot grant of the oldest ready entry
//   any_ready out  at least one entry is ready
module rs_age_picker
  import rs_param_pkg::*;
#(
  parameter int DEPTH = RS_DEPTH_DEFAULT
) (
  input  logic [DEPTH-1:0]            ready,
  input  logic [DEPTH-1:0][DEPTH-1:0] age,
  output logic [DEPTH-1:0]            grant,
  output logic                        any_ready
);

  for (genvar i = 0; i < DEPTH; i++) begin : g_pick
    assign grant[i] = ready[i] & ~(|(ready & age[i]));
  end

  assign any_ready = |ready;

endmodule

// File: rtl/rs_param.sv
// Parametrised ALU-side reservation station.
// Holds renamed instructions until both source tags resolve from N_CDB
// broadcast buses, then issues the oldest ready entry into a 1-deep output
// register with a valid/ready handshake. Whole station flushes on misbranch.
// Optional feature macro: RS_DISPATCH_BYPASS_EN -- a dispatch whose operands
// are all resolved goes straight to the output register when the station has
// nothing ready and the register can load (1-edge latency, no allocation).
// Ports:
//   clk, rst            clock, async active-high reset
//   rdy                 global enable; low freezes all state (flush ignored)
//   in_flush            misbranch flush
//   in_disp_*           dispatch request and payload; out_disp_ready/free_count
//   in_cdb_*            flattened broadcast buses, bus k at [k*W +: W]
//   out_alu_*           issued payload, in_alu_ready accepts
module rs_param
  import rs_param_pkg::*;
#(
  parameter int DEPTH  = RS_DEPTH_DEFAULT,
  parameter int N_CDB  = RS_N_CDB_DEFAULT,
  parameter int TAG_W  = 4,
  parameter int OP_W   = 6,
  parameter int DATA_W = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic                    in_flush,
  input  logic                    in_disp_valid,
  output logic                    out_disp_ready,
  output logic [clog2(DEPTH):0]   out_free_count,
  input  logic [TAG_W-1:0]        in_disp_rob_tag,
  input  logic [OP_W-1:0]         in_disp_op,
  input  logic [DATA_W-1:0]       in_disp_value1,
  input  logic [DATA_W-1:0]       in_disp_value2,
  input  logic [TAG_W-1:0]        in_disp_tag1,
  input  logic [TAG_W-1:0]        in_disp_tag2,
  input  logic [DATA_W-1:0]       in_disp_imm,
  input  logic [DATA_W-1:0]       in_disp_pc,
  input  logic [N_CDB-1:0]        in_cdb_valid,
  input  logic [N_CDB*TAG_W-1:0]  in_cdb_tag,
  input  logic [N_CDB*DATA_W-1:0] in_cdb_value,
  output logic                    out_alu_valid,
  input  logic                    in_alu_ready,
  output logic [OP_W-1:0]         out_alu_op,
  output logic [DATA_W-1:0]       out_alu_value1,
  output logic [DATA_W-1:0]       out_alu_value2,
  output logic [DATA_W-1:0]       out_alu_imm,
  output logic [DATA_W-1:0]       out_alu_pc,
  output logic [TAG_W-1:0]        out_alu_rob_tag
);

  localparam int CNT_W = clog2(DEPTH) + 1;
  localparam logic [TAG_W-1:0] TAG_Z = TAG_W'(TAG_ZERO);

  logic [N_CDB-1:0][TAG_W-1:0]  cdb_tag;
  logic [N_CDB-1:0][DATA_W-1:0] cdb_val;
  assign cdb_tag = in_cdb_tag;
  assign cdb_val = in_cdb_value;

  // entry state, gathered from the per-entry generate blocks
  logic [DEPTH-1:0]            busy;
  logic [DEPTH-1:0][DEPTH-1:0] age;
  logic [DEPTH-1:0]            ready_vec;
  logic [TAG_W-1:0]  e_rob [DEPTH];
  logic [OP_W-1:0]   e_op  [DEPTH];
  logic [DATA_W-1:0] e_val1[DEPTH];
  logic [DATA_W-1:0] e_val2[DEPTH];
  logic [DATA_W-1:0] e_imm [DEPTH];
  logic [DATA_W-1:0] e_pc  [DEPTH];

  // free count / dispatch ready
  logic [CNT_W-1:0] free_cnt;
  always_comb begin
    free_cnt = '0;
    for (int i = 0; i < DEPTH; i++) free_cnt = free_cnt + CNT_W'(~busy[i]);
  end
  assign out_free_count = free_cnt;
  assign out_disp_ready = (free_cnt != '0);

  // lowest-index free slot
  logic [DEPTH-1:0] alloc_oh;
  always_comb begin
    logic found;
    alloc_oh = '0;
    found    = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!busy[i] && !found) begin
        alloc_oh[i] = 1'b1;
        found       = 1'b1;
      end
    end
  end

  // same-cycle capture for the dispatching instruction; descending scan so
  // the lowest matching bus index is the one that sticks
  logic [TAG_W-1:0]  d_tag1, d_tag2;
  logic [DATA_W-1:0] d_val1, d_val2;
  always_comb begin
    d_tag1 = in_disp_tag1;
    d_val1 = in_disp_value1;
    d_tag2 = in_disp_tag2;
    d_val2 = in_disp_value2;
    for (int k = N_CDB - 1; k >= 0; k--) begin
      if (in_cdb_valid[k] && in_disp_tag1 != TAG_Z && cdb_tag[k] == in_disp_tag1) begin
        d_tag1 = TAG_Z;
        d_val1 = cdb_val[k];
      end
      if (in_cdb_valid[k] && in_disp_tag2 != TAG_Z && cdb_tag[k] == in_disp_tag2) begin
        d_tag2 = TAG_Z;
        d_val2 = cdb_val[k];
      end
    end
  end

  // issue selection
  logic [DEPTH-1:0] grant;
  logic             any_ready;

  rs_age_picker #(.DEPTH(DEPTH)) u_pick (
    .ready    (ready_vec),
    .age      (age),
    .grant    (grant),
    .any_ready(any_ready)
  );

  logic can_load, issue, disp_fire, bypass, alloc_en;
  assign can_load  = !out_alu_valid || in_alu_ready;
  assign issue     = can_load && any_ready;
  assign disp_fire = in_disp_valid && out_disp_ready && !in_flush;
`ifdef RS_DISPATCH_BYPASS_EN
  assign bypass    = disp_fire && d_tag1 == TAG_Z && d_tag2 == TAG_Z &&
                     !any_ready && can_load;
`else
  assign bypass    = 1'b0;
`endif
  assign alloc_en  = disp_fire && !bypass;

  logic [DEPTH-1:0] alloc_sel, free_sel;
  assign alloc_sel = alloc_oh & {DEPTH{alloc_en}};
  assign free_sel  = grant & {DEPTH{issue}};

  // one-hot payload mux
  logic [TAG_W-1:0]  s_rob;
  logic [OP_W-1:0]   s_op;
  logic [DATA_W-1:0] s_val1, s_val2, s_imm, s_pc;
  always_comb begin
    s_rob  = '0;
    s_op   = '0;
    s_val1 = '0;
    s_val2 = '0;
    s_imm  = '0;
    s_pc   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (grant[i]) begin
        s_rob  = e_rob[i];
        s_op   = e_op[i];
        s_val1 = e_val1[i];
        s_val2 = e_val2[i];
        s_imm  = e_imm[i];
        s_pc   = e_pc[i];
      end
    end
  end

  // per-entry storage, wakeup and age row
  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    logic              busy_r;
    logic [DEPTH-1:0]  age_r;
    logic [TAG_W-1:0]  tag1_r, tag2_r, rob_r;
    logic [OP_W-1:0]   op_r;
    logic [DATA_W-1:0] val1_r, val2_r, imm_r, pc_r;
    logic [TAG_W-1:0]  w_tag1, w_tag2;
    logic [DATA_W-1:0] w_val1, w_val2;

    always_comb begin
      w_tag1 = tag1_r;
      w_val1 = val1_r;
      w_tag2 = tag2_r;
      w_val2 = val2_r;
      for (int k = N_CDB - 1; k >= 0; k--) begin
        if (in_cdb_valid[k] && tag1_r != TAG_Z && cdb_tag[k] == tag1_r) begin
          w_tag1 = TAG_Z;
          w_val1 = cdb_val[k];
        end
        if (in_cdb_valid[k] && tag2_r != TAG_Z && cdb_tag[k] == tag2_r) begin
          w_tag2 = TAG_Z;
          w_val2 = cdb_val[k];
        end
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        busy_r <= 1'b0;
        age_r  <= '0;
        tag1_r <= '0;
        tag2_r <= '0;
        rob_r  <= '0;
        op_r   <= '0;
        val1_r <= '0;
        val2_r <= '0;
        imm_r  <= '0;
        pc_r   <= '0;
      end else if (rdy) begin
        if (in_flush) begin
          busy_r <= 1'b0;
          age_r  <= '0;
        end else begin
          // new row snapshots everything live; columns of freeing entries drop
          age_r <= (alloc_sel[i] ? busy : age_r) & ~free_sel;
          if (alloc_sel[i]) begin
            busy_r <= 1'b1;
            tag1_r <= d_tag1;
            tag2_r <= d_tag2;
            val1_r <= d_val1;
            val2_r <= d_val2;
            rob_r  <= in_disp_rob_tag;
            op_r   <= in_disp_op;
            imm_r  <= in_disp_imm;
            pc_r   <= in_disp_pc;
          end else begin
            if (free_sel[i]) busy_r <= 1'b0;
            tag1_r <= w_tag1;
            tag2_r <= w_tag2;
            val1_r <= w_val1;
            val2_r <= w_val2;
          end
        end
      end
    end

    assign busy[i]      = busy_r;
    assign age[i]       = age_r;
    assign ready_vec[i] = busy_r && tag1_r == TAG_Z && tag2_r == TAG_Z;
    assign e_rob[i]     = rob_r;
    assign e_op[i]      = op_r;
    assign e_val1[i]    = val1_r;
    assign e_val2[i]    = val2_r;
    assign e_imm[i]     = imm_r;
    assign e_pc[i]      = pc_r;
  end

  // output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_alu_valid   <= 1'b0;
      out_alu_op      <= OP_W'(OP_NOP);
      out_alu_value1  <= '0;
      out_alu_value2  <= '0;
      out_alu_imm     <= '0;
      out_alu_pc      <= '0;
      out_alu_rob_tag <= '0;
    end else if (rdy) begin
      if (in_flush) begin
        out_alu_valid <= 1'b0;
      end else if (issue) begin
        out_alu_valid   <= 1'b1;
        out_alu_op      <= s_op;
        out_alu_value1  <= s_val1;
        out_alu_value2  <= s_val2;
        out_alu_imm     <= s_imm;
        out_alu_pc      <= s_pc;
        out_alu_rob_tag <= s_rob;
      end else if (bypass) begin
        out_alu_valid   <= 1'b1;
        out_alu_op      <= in_disp_op;
        out_alu_value1  <= d_val1;
        out_alu_value2  <= d_val2;
        out_alu_imm     <= in_disp_imm;
        out_alu_pc      <= in_disp_pc;
        out_alu_rob_tag <= in_disp_rob_tag;
      end else if (in_alu_ready) begin
        out_alu_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rs_param.sv
// Directed bench for rs_param with an in-order issue scoreboard.
module tb_rs_param;

  localparam int DEPTH = 16, N_CDB = 3, TAG_W = 4, OP_W = 6, DATA_W = 32;

  logic clk = 1'b0, rst, rdy, in_flush, in_disp_valid, out_disp_ready;
  logic [4:0] out_free_count;
  logic [TAG_W-1:0] in_disp_rob_tag, in_disp_tag1, in_disp_tag2, out_alu_rob_tag;
  logic [OP_W-1:0] in_disp_op, out_alu_op;
  logic [DATA_W-1:0] in_disp_value1, in_disp_value2, in_disp_imm, in_disp_pc;
  logic [N_CDB-1:0] in_cdb_valid;
  logic [N_CDB*TAG_W-1:0] in_cdb_tag;
  logic [N_CDB*DATA_W-1:0] in_cdb_value;
  logic out_alu_valid, in_alu_ready;
  logic [DATA_W-1:0] out_alu_value1, out_alu_value2, out_alu_imm, out_alu_pc;

  rs_param #(.DEPTH(DEPTH), .N_CDB(N_CDB), .TAG_W(TAG_W), .OP_W(OP_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .in_flush(in_flush),
    .in_disp_valid(in_disp_valid), .out_disp_ready(out_disp_ready),
    .out_free_count(out_free_count), .in_disp_rob_tag(in_disp_rob_tag),
    .in_disp_op(in_disp_op), .in_disp_value1(in_disp_value1),
    .in_disp_value2(in_disp_value2), .in_disp_tag1(in_disp_tag1),
    .in_disp_tag2(in_disp_tag2), .in_disp_imm(in_disp_imm), .in_disp_pc(in_disp_pc),
    .in_cdb_valid(in_cdb_valid), .in_cdb_tag(in_cdb_tag), .in_cdb_value(in_cdb_value),
    .out_alu_valid(out_alu_valid), .in_alu_ready(in_alu_ready),
    .out_alu_op(out_alu_op), .out_alu_value1(out_alu_value1),
    .out_alu_value2(out_alu_value2), .out_alu_imm(out_alu_imm),
    .out_alu_pc(out_alu_pc), .out_alu_rob_tag(out_alu_rob_tag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [TAG_W-1:0]  rob;
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] v1, v2, imm, pc;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int fails  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void push(input logic [TAG_W-1:0] rob, input logic [OP_W-1:0] op,
                               input logic [DATA_W-1:0] v1, input logic [DATA_W-1:0] v2);
    exp_t e;
    e.rob = rob; e.op = op; e.v1 = v1; e.v2 = v2;
    e.imm = 32'h100 + 32'(rob);
    e.pc  = 32'h4000 + 32'(rob);
    sb.push_back(e);
  endfunction

  // handshake monitor: every accepted issue must match the scoreboard head
  always @(negedge clk) begin
    if (!rst && out_alu_valid && in_alu_ready) begin
      chk("sb_nonempty", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("iss_rob", out_alu_rob_tag, e.rob);
        chk("iss_op", out_alu_op, e.op);
        chk("iss_v1", out_alu_value1, e.v1);
        chk("iss_v2", out_alu_value2, e.v2);
        chk("iss_imm", out_alu_imm, e.imm);
        chk("iss_pc", out_alu_pc, e.pc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic disp(input logic [TAG_W-1:0] rob, input logic [OP_W-1:0] op,
                      input logic [DATA_W-1:0] v1, input logic [DATA_W-1:0] v2,
                      input logic [TAG_W-1:0] t1, input logic [TAG_W-1:0] t2);
    chk("disp_not_full", out_disp_ready, 1);
    in_disp_rob_tag = rob; in_disp_op = op;
    in_disp_value1 = v1; in_disp_value2 = v2;
    in_disp_tag1 = t1; in_disp_tag2 = t2;
    in_disp_imm = 32'h100 + 32'(rob);
    in_disp_pc  = 32'h4000 + 32'(rob);
    in_disp_valid = 1'b1;
    tick();
    in_disp_valid = 1'b0;
  endtask

  task automatic cdb(input int b, input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] v);
    in_cdb_valid[b] = 1'b1;
    in_cdb_tag[b*TAG_W +: TAG_W] = t;
    in_cdb_value[b*DATA_W +: DATA_W] = v;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; rdy = 1'b1; in_flush = 1'b0; in_disp_valid = 1'b0;
    in_disp_rob_tag = '0; in_disp_op = '0; in_disp_value1 = '0; in_disp_value2 = '0;
    in_disp_tag1 = '0; in_disp_tag2 = '0; in_disp_imm = '0; in_disp_pc = '0;
    in_cdb_valid = '0; in_cdb_tag = '0; in_cdb_value = '0; in_alu_ready = 1'b1;
    #12;
    chk("rst_valid", out_alu_valid, 0);
    chk("rst_op", out_alu_op, 0);
    chk("rst_free", out_free_count, 16);
    chk("rst_dready", out_disp_ready, 1);
    @(negedge clk); rst = 1'b0;
    tick();

    // basic latency
    push(5, 6'h01, 3, 4);
    disp(5, 6'h01, 3, 4, 0, 0);
`ifdef RS_DISPATCH_BYPASS_EN
    chk("lat_valid_e1", out_alu_valid, 1);
    chk("lat_rob", out_alu_rob_tag, 5);
`else
    chk("lat_valid_e1", out_alu_valid, 0);
    tick();
    chk("lat_valid_e2", out_alu_valid, 1);
    chk("lat_rob", out_alu_rob_tag, 5);
    chk("lat_v1", out_alu_value1, 3);
    chk("lat_v2", out_alu_value2, 4);
`endif
    repeat (2) tick();
    chk("lat_drained", 32'(sb.size()), 0);

    // two waiters on one tag, woken by bus 2
    push(2, 6'h02, 32'hAB, 32'h22);
    push(3, 6'h02, 32'hAB, 32'h33);
    disp(2, 6'h02, 0, 32'h22, 7, 0);
    disp(3, 6'h02, 0, 32'h33, 7, 0);
    tick();
    chk("wait_idle", out_alu_valid, 0);
    cdb(2, 7, 32'hAB); tick(); in_cdb_valid = '0;
    tick();
    chk("wake_first", out_alu_rob_tag, 2);
    chk("wake_first_v1", out_alu_value1, 32'hAB);
    tick();
    chk("wake_second", out_alu_rob_tag, 3);
    chk("wake_second_v1", out_alu_value1, 32'hAB);
    tick();
    chk("wake_drained", 32'(sb.size()), 0);

    // age order differs from slot order: c reuses slot 0 but is younger than b
    push(10, 6'h03, 32'hA0, 0);
    push(11, 6'h03, 32'hB0, 1);
    push(12, 6'h03, 32'hB0, 2);
    disp(10, 6'h03, 0, 0, 10, 0);
    disp(11, 6'h03, 0, 1, 8, 0);
    cdb(0, 10, 32'hA0); tick(); in_cdb_valid = '0;
    repeat (2) tick();
    disp(12, 6'h03, 0, 2, 8, 0);
    cdb(1, 8, 32'hB0); tick(); in_cdb_valid = '0;
    repeat (4) tick();
    chk("age_drained", 32'(sb.size()), 0);

    // same-cycle capture at dispatch
    push(6, 6'h04, 32'h66, 32'h11);
    cdb(0, 9, 32'h11);
    disp(6, 6'h04, 32'h66, 0, 0, 9);
    in_cdb_valid = '0;
    repeat (3) tick();
    chk("cap_drained", 32'(sb.size()), 0);
    chk("cap_free", out_free_count, 16);

    // fill, then stall the output for 4 cycles
    in_alu_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      push(TAG_W'((i % 15) + 1), 6'h05, 32'h55, 32'(i));
      disp(TAG_W'((i % 15) + 1), 6'h05, 0, 32'(i), 15, 0);
    end
    chk("full_dready", out_disp_ready, 0);
    chk("full_free", out_free_count, 0);
    cdb(1, 15, 32'h55); tick(); in_cdb_valid = '0;
    tick();
    chk("stall_free", out_free_count, 1);
    for (int c = 0; c < 4; c++) begin
      chk("stall_valid", out_alu_valid, 1);
      chk("stall_rob", out_alu_rob_tag, 1);
      chk("stall_v1", out_alu_value1, 32'h55);
      chk("stall_v2", out_alu_value2, 0);
      tick();
    end
    in_alu_ready = 1'b1;
    for (int c = 0; c < 40 && sb.size() != 0; c++) tick();
    chk("fill_drained", 32'(sb.size()), 0);
    tick();

    // flush with 10 busy entries and a valid output
    in_alu_ready = 1'b0;
    disp(1, 6'h06, 1, 1, 0, 0);
    for (int i = 0; i < 10; i++) disp(TAG_W'(i + 2), 6'h06, 0, 0, 12, 0);
    repeat (2) tick();
    chk("pre_flush_valid", out_alu_valid, 1);
    chk("pre_flush_free", out_free_count, 6);
    in_flush = 1'b1; tick(); in_flush = 1'b0;
    chk("flush_free", out_free_count, 16);
    chk("flush_valid", out_alu_valid, 0);
    in_alu_ready = 1'b1;
    cdb(0, 12, 32'h77); tick(); in_cdb_valid = '0;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("post_flush_idle", out_alu_valid, 0);
    end

    // rdy low freezes state and ignores flush
    disp(9, 6'h07, 0, 0, 3, 0);
    chk("rdy_pre_free", out_free_count, 15);
    rdy = 1'b0; in_flush = 1'b1;
    tick();
    chk("rdy_hold_free", out_free_count, 15);
    in_flush = 1'b0; rdy = 1'b1;
    push(9, 6'h07, 32'hCC, 0);
    cdb(2, 3, 32'hCC); tick(); in_cdb_valid = '0;
    repeat (3) tick();
    chk("rdy_drained", 32'(sb.size()), 0);
    chk("rdy_free", out_free_count, 16);

    // asynchronous reset mid-run with 5 busy entries
    in_alu_ready = 1'b0;
    disp(1, 6'h08, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) disp(TAG_W'(i + 2), 6'h08, 0, 0, 4, 0);
    repeat (2) tick();
    chk("pre_rst_valid", out_alu_valid, 1);
    chk("pre_rst_free", out_free_count, 11);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", out_alu_valid, 0);
    chk("async_rst_free", out_free_count, 16);
    @(negedge clk); rst = 1'b0;
    tick();
    chk("after_rst_free", out_free_count, 16);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
